page_table_param: RTL and testbench

//  Parametrised single-level page table; successor to the fixed 32B table.
//  - Holds 2**VPN_W translations of PPN_W bits, each with a valid bit.
//  - Serves one lookup at a time with fixed, programmable walk latency.
//  - Reports a fault on invalid entries; supports insert and invalidate.
//  - Sits behind the speculative TLB as its miss-handling backing store.

---
 rtl/pt_pkg.sv | 29 ++
 rtl/pt_stat_counter.sv | 24 ++
 rtl/page_table_param.sv | 138 +++++++++++++
 tb/tb_page_table_param.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pt_pkg.sv
// Shared types and helpers for the parametrised page table.
// Consumers import pt_pkg::* for the walk FSM states, entry layout and counter sizing.
package pt_pkg;

  // Walk controller states
  typedef enum logic [0:0] {
    PT_IDLE = 1'b0,
    PT_WALK = 1'b1
  } pt_state_e;

  // Entry layout at the default translation width
  localparam int unsigned PT_DEF_PPN_W = 6;

  typedef struct packed {
    logic                    valid;
    logic [PT_DEF_PPN_W-1:0] ppn;
  } pt_entry_t;

  // Bits needed to hold LOOKUP_LAT-1; never less than one so the counter always exists
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 1;
    while ((64'd1 << bits) < 64'(value)) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/pt_stat_counter.sv
// Saturating up-counter used for page-table walk statistics.
// Holds at all-ones once reached; cleared only by the synchronous reset.
module pt_stat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/page_table_param.sv
// Parametrised single-level page table with a fixed-latency lookup walk.
// Optional statistics counters are built when PT_STATS_EN is defined.
module page_table_param
  import pt_pkg::*;
#(
  parameter int unsigned VPN_W      = 3,
  parameter int unsigned PPN_W      = 6,
  parameter int unsigned LOOKUP_LAT = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             LOOKUP_RQST,
  input  logic [VPN_W-1:0] LOOKUP_ADDR,
  output logic             LOOKUP_BUSY,
  output logic             LOOKUP_COMPLETE,
  output logic [PPN_W-1:0] LOOKUP_RETURN,
  output logic             LOOKUP_FAULT,
  input  logic             PT_INSERT_RQST,
  input  logic [VPN_W-1:0] PT_INSERT_INDX,
  input  logic [PPN_W-1:0] PT_INSERT_ENTRY,
  input  logic             PT_INVAL_RQST,
  input  logic [VPN_W-1:0] PT_INVAL_INDX,
  output logic [CNT_W-1:0] STAT_LOOKUPS,
  output logic [CNT_W-1:0] STAT_FAULTS
);

  localparam int unsigned DEPTH = 2 ** VPN_W;
  localparam int unsigned LAT_W = clog2(LOOKUP_LAT);

  // Same shape as pt_entry_t, sized by this instance's translation width
  typedef struct packed {
    logic             valid;
    logic [PPN_W-1:0] ppn;
  } entry_t;

  entry_t           table_q [DEPTH];
  pt_state_e        state_q;
  logic [LAT_W-1:0] cnt_q;
  logic [VPN_W-1:0] addr_q;
  logic             busy_q;
  logic             complete_q;
  logic             fault_q;
  logic [PPN_W-1:0] return_q;

  logic             walk_done_c;
  entry_t           rd_entry_c;

  assign walk_done_c = (state_q == PT_WALK) && (cnt_q == '0);
  assign rd_entry_c  = table_q[addr_q];

  // Table storage: reset clears valid bits only; insert is applied after invalidate so it wins
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i].valid <= 1'b0;
      end
    end else begin
      if (PT_INVAL_RQST) begin
        table_q[PT_INVAL_INDX].valid <= 1'b0;
      end
      if (PT_INSERT_RQST) begin
        table_q[PT_INSERT_INDX].valid <= 1'b1;
        table_q[PT_INSERT_INDX].ppn   <= PT_INSERT_ENTRY;
      end
    end
  end

  // Walk FSM; the final read samples the table before any same-edge write lands
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PT_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
      fault_q    <= 1'b0;
      return_q   <= '0;
    end else begin
      complete_q <= 1'b0;
      case (state_q)
        PT_IDLE: begin
          if (LOOKUP_RQST) begin
            state_q <= PT_WALK;
            busy_q  <= 1'b1;
            addr_q  <= LOOKUP_ADDR;
            cnt_q   <= LAT_W'(LOOKUP_LAT - 1);
          end
        end
        PT_WALK: begin
          if (walk_done_c) begin
            state_q    <= PT_IDLE;
            busy_q     <= 1'b0;
            complete_q <= 1'b1;
            fault_q    <= ~rd_entry_c.valid;
            return_q   <= rd_entry_c.valid ? rd_entry_c.ppn : '0;
          end else begin
            cnt_q <= cnt_q - LAT_W'(1);
          end
        end
        default: begin
          state_q <= PT_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign LOOKUP_BUSY     = busy_q;
  assign LOOKUP_COMPLETE = complete_q;
  assign LOOKUP_FAULT    = fault_q;
  assign LOOKUP_RETURN   = return_q;

`ifdef PT_STATS_EN
  // Counters advance on the same edge that raises COMPLETE
  pt_stat_counter #(
    .CNT_W (CNT_W)
  ) u_stat_lookups (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (walk_done_c),
    .count_o (STAT_LOOKUPS)
  );

  pt_stat_counter #(
    .CNT_W (CNT_W)
  ) u_stat_faults (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (walk_done_c && !rd_entry_c.valid),
    .count_o (STAT_FAULTS)
  );
`else
  assign STAT_LOOKUPS = '0;
  assign STAT_FAULTS  = '0;
`endif

endmodule

// File: tb/tb_page_table_param.sv
// Self-checking bench for page_table_param against an array-based reference model.
module tb_page_table_param;

  localparam int unsigned VPN_W      = 3;
  localparam int unsigned PPN_W      = 6;
  localparam int unsigned LOOKUP_LAT = 2;
  localparam int unsigned CNT_W      = 2;
  localparam int unsigned DEPTH      = 2 ** VPN_W;
  localparam int unsigned WAIT_MAX   = 20;
`ifdef PT_STATS_EN
  localparam int unsigned STAT_MAX   = (2 ** CNT_W) - 1;
`else
  localparam int unsigned STAT_MAX   = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             LOOKUP_RQST;
  logic [VPN_W-1:0] LOOKUP_ADDR;
  logic             LOOKUP_BUSY;
  logic             LOOKUP_COMPLETE;
  logic [PPN_W-1:0] LOOKUP_RETURN;
  logic             LOOKUP_FAULT;
  logic             PT_INSERT_RQST;
  logic [VPN_W-1:0] PT_INSERT_INDX;
  logic [PPN_W-1:0] PT_INSERT_ENTRY;
  logic             PT_INVAL_RQST;
  logic [VPN_W-1:0] PT_INVAL_INDX;
  logic [CNT_W-1:0] STAT_LOOKUPS;
  logic [CNT_W-1:0] STAT_FAULTS;

  page_table_param #(
    .VPN_W      (VPN_W),
    .PPN_W      (PPN_W),
    .LOOKUP_LAT (LOOKUP_LAT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .LOOKUP_RQST     (LOOKUP_RQST),
    .LOOKUP_ADDR     (LOOKUP_ADDR),
    .LOOKUP_BUSY     (LOOKUP_BUSY),
    .LOOKUP_COMPLETE (LOOKUP_COMPLETE),
    .LOOKUP_RETURN   (LOOKUP_RETURN),
    .LOOKUP_FAULT    (LOOKUP_FAULT),
    .PT_INSERT_RQST  (PT_INSERT_RQST),
    .PT_INSERT_INDX  (PT_INSERT_INDX),
    .PT_INSERT_ENTRY (PT_INSERT_ENTRY),
    .PT_INVAL_RQST   (PT_INVAL_RQST),
    .PT_INVAL_INDX   (PT_INVAL_INDX),
    .STAT_LOOKUPS    (STAT_LOOKUPS),
    .STAT_FAULTS     (STAT_FAULTS)
  );

  always #5 clk = ~clk;

  // Reference model: valid flags, translations and completed-lookup tallies
  bit               mv [DEPTH];
  logic [PPN_W-1:0] mp [DEPTH];
  int unsigned      n_lookups;
  int unsigned      n_faults;
  int unsigned      tests;
  int unsigned      failed;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int unsigned n);
    return 32'((n > STAT_MAX) ? STAT_MAX : n);
  endfunction

  task automatic chk_stats(input string tag);
    chk({tag, "_stat_lookups"}, 32'(STAT_LOOKUPS), sat(n_lookups));
    chk({tag, "_stat_faults"},  32'(STAT_FAULTS),  sat(n_faults));
  endtask

  // One-cycle table write; model applies invalidate then insert
  task automatic wr(input bit ins, input logic [VPN_W-1:0] ii, input logic [PPN_W-1:0] ie,
                    input bit inv, input logic [VPN_W-1:0] vi);
    PT_INSERT_RQST  = ins;
    PT_INSERT_INDX  = ii;
    PT_INSERT_ENTRY = ie;
    PT_INVAL_RQST   = inv;
    PT_INVAL_INDX   = vi;
    step();
    PT_INSERT_RQST  = 1'b0;
    PT_INVAL_RQST   = 1'b0;
    if (inv) mv[vi] = 1'b0;
    if (ins) begin
      mv[ii] = 1'b1;
      mp[ii] = ie;
    end
  endtask

  // Lookup; optional insert at edge 'wedge' after acceptance (0 = none).
  // Expectation is the model state just before the completing edge.
  task automatic lookup(input string tag, input logic [VPN_W-1:0] a, input int unsigned wedge,
                        input logic [VPN_W-1:0] wi, input logic [PPN_W-1:0] wd);
    int unsigned      lat;
    bit               snap_v;
    logic [PPN_W-1:0] snap_p;
    LOOKUP_RQST = 1'b1;
    LOOKUP_ADDR = a;
    step();
    LOOKUP_RQST = 1'b0;
    chk({tag, "_busy"}, 32'(LOOKUP_BUSY), 32'd1);
    lat    = 0;
    snap_v = 1'b0;
    snap_p = '0;
    for (int unsigned k = 1; k <= WAIT_MAX; k++) begin
      snap_v = mv[a];
      snap_p = mp[a];
      if (k == wedge) begin
        PT_INSERT_RQST  = 1'b1;
        PT_INSERT_INDX  = wi;
        PT_INSERT_ENTRY = wd;
      end
      step();
      if (k == wedge) begin
        PT_INSERT_RQST = 1'b0;
        mv[wi] = 1'b1;
        mp[wi] = wd;
      end
      if (LOOKUP_COMPLETE) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(LOOKUP_LAT));
    chk({tag, "_fault"}, 32'(LOOKUP_FAULT), 32'(!snap_v));
    chk({tag, "_return"}, 32'(LOOKUP_RETURN), snap_v ? 32'(snap_p) : 32'd0);
    if (lat != 0) begin
      n_lookups++;
      if (!snap_v) n_faults++;
    end
    chk_stats(tag);
    step();
    chk({tag, "_pulse"}, 32'(LOOKUP_COMPLETE), 32'd0);
    chk({tag, "_hold"}, 32'(LOOKUP_RETURN), snap_v ? 32'(snap_p) : 32'd0);
  endtask

  initial begin
    int unsigned completes;
    tests = 0;
    failed = 0;
    n_lookups = 0;
    n_faults = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mv[i] = 1'b0;
      mp[i] = '0;
    end
    rst = 1'b1;
    LOOKUP_RQST = 1'b0;
    LOOKUP_ADDR = '0;
    PT_INSERT_RQST = 1'b0;
    PT_INSERT_INDX = '0;
    PT_INSERT_ENTRY = '0;
    PT_INVAL_RQST = 1'b0;
    PT_INVAL_INDX = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_busy", 32'(LOOKUP_BUSY), 32'd0);
    chk("rst_complete", 32'(LOOKUP_COMPLETE), 32'd0);
    chk("rst_fault", 32'(LOOKUP_FAULT), 32'd0);
    chk("rst_return", 32'(LOOKUP_RETURN), 32'd0);
    chk_stats("rst");

    // Empty table faults; insert then hit
    lookup("t1", 3'd5, 0, '0, '0);
    wr(1'b1, 3'd5, 6'b101010, 1'b0, '0);
    lookup("t2", 3'd5, 0, '0, '0);

    // Request presented while busy is dropped
    LOOKUP_RQST = 1'b1;
    LOOKUP_ADDR = 3'd5;
    step();
    LOOKUP_ADDR = 3'd2;
    completes = 0;
    for (int unsigned k = 1; k <= LOOKUP_LAT; k++) begin
      step();
      if (LOOKUP_COMPLETE) completes++;
    end
    LOOKUP_RQST = 1'b0;
    chk("t3_complete", 32'(LOOKUP_COMPLETE), 32'd1);
    chk("t3_return", 32'(LOOKUP_RETURN), 32'h2a);
    n_lookups++;
    for (int k = 0; k < 4; k++) begin
      step();
      if (LOOKUP_COMPLETE) completes++;
    end
    chk("t3_one_complete", 32'(completes), 32'd1);
    chk("t3_idle", 32'(LOOKUP_BUSY), 32'd0);

    // Insert at the final-read edge is not seen; next lookup sees it
    lookup("t4a", 3'd5, LOOKUP_LAT, 3'd5, 6'h15);
    chk("t4a_old", 32'(LOOKUP_RETURN), 32'h2a);
    lookup("t4b", 3'd5, 0, '0, '0);
    chk("t4b_new", 32'(LOOKUP_RETURN), 32'h15);

    // Insert beats same-index invalidate; invalidate alone faults
    wr(1'b1, 3'd3, 6'h33, 1'b1, 3'd3);
    lookup("t5a", 3'd3, 0, '0, '0);
    wr(1'b0, '0, '0, 1'b1, 3'd3);
    lookup("t5b", 3'd3, 0, '0, '0);

    // Five faulting lookups drive saturation when counters exist
    for (int k = 0; k < 5; k++) lookup("t6", 3'd7, 0, '0, '0);

    // Reset mid-walk aborts without COMPLETE and clears state
    LOOKUP_RQST = 1'b1;
    LOOKUP_ADDR = 3'd5;
    step();
    LOOKUP_RQST = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
    n_lookups = 0;
    n_faults = 0;
    completes = 0;
    for (int k = 0; k < 4; k++) begin
      if (LOOKUP_COMPLETE) completes++;
      step();
    end
    chk("t6_no_complete", 32'(completes), 32'd0);
    chk("t6_busy", 32'(LOOKUP_BUSY), 32'd0);
    chk_stats("t6_rst");
    lookup("t6_post", 3'd5, 0, '0, '0);

    // Randomised writes and lookups, including mid-walk inserts
    for (int n = 0; n < 40; n++) begin
      logic [VPN_W-1:0] ii;
      logic [VPN_W-1:0] vi;
      ii = VPN_W'($urandom_range(0, DEPTH - 1));
      vi = ($urandom_range(0, 1) == 1) ? ii : VPN_W'($urandom_range(0, DEPTH - 1));
      wr(1'($urandom_range(0, 1)), ii, PPN_W'($urandom), 1'($urandom_range(0, 1)), vi);
      lookup("rnd", VPN_W'($urandom_range(0, DEPTH - 1)), $urandom_range(0, LOOKUP_LAT),
             VPN_W'($urandom_range(0, DEPTH - 1)), PPN_W'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
